instr_mem_block: RTL and testbench
==================================

# instr_mem_block

Block-organised instruction memory behind the instruction cache. It holds the program image as 64 blocks of 128 bits and serves one whole block per cache miss after a fixed, parameterised latency. The read side uses the cache's busywait handshake. A word-wide load port fills the program image from the bench or boot logic.

## Interface

Parameters:
- LATENCY, 4: cycles from request acceptance to data delivery; legal range 1..255.
- NUM_BLOCKS, 64: block count; the block address is log2(NUM_BLOCKS) bits wide.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_read  in  1  block read request, level; held by the cache while it waits.
- imem_pc  in  6  block address: cache tag concatenated with index.
- imem_readdata  out  128  returned block; word w is at bits [32w+31:32w].
- imem_busywait  out  1  high while a read is in flight.
- load_en  in  1  write one 32-bit word this cycle.
- load_addr  in  8  word address: block = load_addr[7:2], word = load_addr[1:0].
- load_data  in  32  word to write.
- load_drop  out  1  one-cycle pulse when a load is rejected.

## Operation

State machine states: IDLE, READ, DONE.

IDLE:
- If imem_read is sampled 1, latch imem_pc into addr_q.
- Load the wait counter with LATENCY-1, set busywait to 1, go to READ.
- Otherwise stay in IDLE.

READ:
- If imem_read is sampled 0, abort: busywait goes to 0, go to IDLE, imem_readdata unchanged.
- Else if counter == 0: imem_readdata <= mem[addr_q], busywait goes to 0, go to DONE.
- Otherwise decrement the counter.

DONE:
- Always go to IDLE, even if imem_read is still high.
- This gives the cache one cycle to see busywait low and drop its request.
- A request still high in IDLE starts a new read.

General rules:
- imem_readdata holds its last value until the next completed read.
- imem_pc changes while in READ are ignored, because the address is latched at acceptance.
- Loads are accepted in IDLE and DONE only.
- An accepted load writes load_data into mem[load_addr[7:2]] word lane load_addr[1:0] at the clock edge.
- Loads in READ are discarded and load_drop pulses for that cycle, so a block cannot change under an in-flight read.
- A load and a read request in the same IDLE cycle: both are taken. The load writes first, so the new word is visible to that read.

## Timing

- Reset values: imem_busywait 0, imem_readdata 0, load_drop 0, state IDLE, counter 0. Memory contents are not reset.
- Reset asserted mid-read aborts the read immediately and asynchronously. No data is returned, and outputs take their reset values.
- Latency: request sampled at edge E0. imem_busywait is high from E0 through E0+LATENCY. It falls at edge E0+LATENCY, together with valid imem_readdata.
- Back-to-back reads: the minimum spacing between acceptances is LATENCY+2 edges.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

Shared package `imem_pkg`:
- BLOCK_BITS = 128, WORD_BITS = 32, WORDS_PER_BLOCK = 4.
- State encoding: IDLE = 2'd0, READ = 2'd1, DONE = 2'd2.
- This package is shared with the instruction cache for the block width and the imem_pc width.

Sub-module `imem_wait_counter`:
- Loadable down-counter with a zero flag.
- Ports: load, load_value, dec, zero.

## Test plan

- Reset low for 2 cycles, then release -> busywait=0, readdata=0, state IDLE. A read of an unloaded block returns unknown data without hanging.
- Load words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at addresses 0x14..0x17, then read imem_pc=5 -> busywait high exactly 4 cycles; readdata = 0x44444444_33333333_22222222_11111111 at the falling edge.
- Hold imem_read high across DONE with imem_pc=6 -> exactly one DONE cycle with busywait=0, then a second read of block 6 starts; acceptance spacing is 6 edges.
- Load to 0x14 while in READ -> load_drop pulses 1 cycle and block 5 is unchanged on re-read. A load issued in the same cycle as the request -> the new word is returned.
- Drop imem_read in the 2nd READ cycle -> busywait falls next edge and readdata keeps its old value. Assert reset mid-read -> busywait drops asynchronously.
- LATENCY=1 build -> busywait high for exactly one cycle per read.

Source files
------------

// File: rtl/imem_pkg.sv
// Instruction-memory geometry and FSM encoding.
// Shared with the instruction cache for block and block-address widths.
package imem_pkg;

    localparam int BLOCK_BITS      = 128;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int PC_BITS         = 6;
    localparam int CNT_BITS        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_wait_counter.sv
// Loadable down-counter used to time the memory read latency.
module imem_wait_counter
    import imem_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_value,
    input  logic                dec,
    output logic                zero
);

    logic [CNT_BITS-1:0] count_d;
    logic [CNT_BITS-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/instr_mem_block.sv
// Block-organised instruction memory: returns one 128-bit block per
// cache miss after LATENCY cycles, with a word-wide program load port.
module instr_mem_block
    import imem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 2 ** PC_BITS
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            imem_read,
    input  logic [$clog2(NUM_BLOCKS)-1:0]   imem_pc,
    output logic [BLOCK_BITS-1:0]           imem_readdata,
    output logic                            imem_busywait,
    input  logic                            load_en,
    input  logic [$clog2(NUM_BLOCKS)+1:0]   load_addr,
    input  logic [WORD_BITS-1:0]            load_data,
    output logic                            load_drop
);

    localparam int AW = $clog2(NUM_BLOCKS);
    localparam logic [CNT_BITS-1:0] WAIT_INIT = CNT_BITS'(LATENCY - 1);

    logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] mem [NUM_BLOCKS];

    imem_state_e           state_d, state_q;
    logic [AW-1:0]         addr_d, addr_q;
    logic                  busy_d, busy_q;
    logic [BLOCK_BITS-1:0] rdata_d, rdata_q;
    logic                  drop_d, drop_q;

    logic                  cnt_load, cnt_dec, cnt_zero;
    logic                  load_ok;
    logic [AW-1:0]         load_blk;
    logic [1:0]            load_lane;

    assign load_blk  = load_addr[AW+1:2];
    assign load_lane = load_addr[1:0];
    // Loads are frozen while a read is in flight so the block stays stable.
    assign load_ok   = load_en && (state_q != READ);

    imem_wait_counter u_wait (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (WAIT_INIT),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        drop_d   = load_en && (state_q == READ);
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (imem_read) begin
                    addr_d   = imem_pc;
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = READ;
                end
            end
            READ: begin
                if (!imem_read) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    rdata_d = mem[addr_q];
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[load_blk][load_lane] <= load_data;
        end
    end

    assign imem_readdata = rdata_q;
    assign imem_busywait = busy_q;
    assign load_drop     = drop_q;

endmodule

// File: tb/tb_instr_mem_block.sv
// Directed and randomized checks of instr_mem_block against a block-array model.
module tb_instr_mem_block;

    import imem_pkg::*;

    localparam int LAT = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         imem_read;
    logic [5:0]   imem_pc;
    logic [127:0] imem_readdata;
    logic         imem_busywait;
    logic         load_en;
    logic [7:0]   load_addr;
    logic [31:0]  load_data;
    logic         load_drop;

    logic         rd1;
    logic [5:0]   pc1;
    logic [127:0] rdata1;
    logic         busy1;
    logic         l1_en;
    logic [7:0]   l1_addr;
    logic [31:0]  l1_data;
    logic         drop1;

    logic [3:0][31:0] model [64];
    logic [3:0][31:0] m1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    instr_mem_block #(.LATENCY(LAT), .NUM_BLOCKS(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_read     (imem_read),
        .imem_pc       (imem_pc),
        .imem_readdata (imem_readdata),
        .imem_busywait (imem_busywait),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_drop     (load_drop)
    );

    instr_mem_block #(.LATENCY(1), .NUM_BLOCKS(64)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .imem_read     (rd1),
        .imem_pc       (pc1),
        .imem_readdata (rdata1),
        .imem_busywait (busy1),
        .load_en       (l1_en),
        .load_addr     (l1_addr),
        .load_data     (l1_data),
        .load_drop     (drop1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
        model[a[7:2]][a[1:0]] = d;
    endtask

    // Counts cycles with busywait high after the acceptance edge.
    task automatic wait_fall(output int n);
        n = 0;
        while (imem_busywait === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic do_read(input logic [5:0] pc, output int n,
                           output logic [127:0] d);
        imem_read = 1'b1;
        imem_pc   = pc;
        tick();
        imem_pc = 6'($urandom);
        wait_fall(n);
        d = imem_readdata;
        imem_read = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           e0;
        logic [127:0] d;
        logic [127:0] old;
        logic [5:0]   blks [8];

        reset     = 1'b0;
        imem_read = 1'b0;
        imem_pc   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        rd1       = 1'b0;
        pc1       = '0;
        l1_en     = 1'b0;
        l1_addr   = '0;
        l1_data   = '0;

        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_busy", 128'(imem_busywait), 128'd0);
        chk("rst_rdata", imem_readdata, 128'd0);
        chk("rst_drop", 128'(load_drop), 128'd0);
        chk("rst_state", {126'd0, dut.state_q}, 128'd0);

        do_read(6'd40, n, d);
        chk("unloaded_lat", 128'(n), 128'(LAT));

        load_word(8'h14, 32'h11111111);
        load_word(8'h15, 32'h22222222);
        load_word(8'h16, 32'h33333333);
        load_word(8'h17, 32'h44444444);
        chk("load_nodrop", 128'(load_drop), 128'd0);
        do_read(6'd5, n, d);
        chk("blk5_lat", 128'(n), 128'(LAT));
        chk("blk5_data", d,
            128'h44444444_33333333_22222222_11111111);

        for (int w = 0; w < 4; w++) load_word({6'd6, 2'(w)}, $urandom);
        imem_read = 1'b1;
        imem_pc   = 6'd6;
        tick();
        e0 = cyc;
        wait_fall(n);
        chk("hold_lat", 128'(n), 128'(LAT));
        chk("hold_data", imem_readdata, model[6]);
        tick();
        chk("done_busy_low", 128'(imem_busywait), 128'd0);
        tick();
        chk("rearm_busy", 128'(imem_busywait), 128'd1);
        chk("rearm_spacing", 128'(cyc - e0), 128'(LAT + 2));
        wait_fall(n);
        chk("rearm_lat", 128'(n), 128'(LAT));
        chk("rearm_data", imem_readdata, model[6]);
        imem_read = 1'b0;
        tick();

        imem_read = 1'b1;
        imem_pc   = 6'd5;
        tick();
        load_en   = 1'b1;
        load_addr = 8'h14;
        load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        chk("drop_pulse", 128'(load_drop), 128'd1);
        tick();
        chk("drop_end", 128'(load_drop), 128'd0);
        wait_fall(n);
        chk("drop_data", imem_readdata, model[5]);
        imem_read = 1'b0;
        tick();
        do_read(6'd5, n, d);
        chk("drop_reread", d, model[5]);

        load_en   = 1'b1;
        load_addr = 8'h15;
        load_data = 32'hCAFEF00D;
        imem_read = 1'b1;
        imem_pc   = 6'd5;
        tick();
        load_en = 1'b0;
        model[5][1] = 32'hCAFEF00D;
        chk("same_nodrop", 128'(load_drop), 128'd0);
        wait_fall(n);
        chk("same_lat", 128'(n), 128'(LAT));
        chk("same_data", imem_readdata, model[5]);
        imem_read = 1'b0;
        tick();

        old       = imem_readdata;
        imem_read = 1'b1;
        imem_pc   = 6'd6;
        tick();
        tick();
        chk("abort_busy_pre", 128'(imem_busywait), 128'd1);
        imem_read = 1'b0;
        tick();
        chk("abort_busy", 128'(imem_busywait), 128'd0);
        chk("abort_rdata", imem_readdata, old);
        tick();

        imem_read = 1'b1;
        imem_pc   = 6'd6;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 128'(imem_busywait), 128'd0);
        chk("arst_rdata", imem_readdata, 128'd0);
        imem_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_read(6'd5, n, d);
        chk("post_rst_data", d, model[5]);

        for (int i = 0; i < 8; i++) begin
            blks[i] = 6'($urandom);
            for (int w = 0; w < 4; w++)
                load_word({blks[i], 2'(w)}, $urandom);
        end
        for (int i = 0; i < 24; i++) begin
            logic [5:0] b;
            if ($urandom_range(0, 2) == 0)
                load_word({blks[$urandom_range(0, 7)], 2'($urandom)},
                          $urandom);
            b = blks[$urandom_range(0, 7)];
            do_read(b, n, d);
            chk("rand_lat", 128'(n), 128'(LAT));
            chk("rand_data", d, model[b]);
        end

        for (int w = 0; w < 4; w++) begin
            l1_en   = 1'b1;
            l1_addr = {6'd3, 2'(w)};
            l1_data = $urandom;
            m1[w]   = l1_data;
            tick();
        end
        l1_en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rd1 = 1'b1;
            pc1 = 6'd3;
            tick();
            n = 0;
            while (busy1 === 1'b1 && n < 300) begin
                n++;
                tick();
            end
            chk("lat1_cycles", 128'(n), 128'd1);
            chk("lat1_data", rdata1, m1);
            rd1 = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
